// File: rtl/memio_pkg.sv
// Shared definitions for the data-side memory/I-O access unit:
// FSM state type, load/store opcode constants and the default I/O window base.
package memio_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAM_RD,
        S_IO_WAIT,
        S_DONE
    } state_t;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFFFC00;
    localparam logic [31:0] IO_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_io_unit_lane_formatter.sv
// Combinational lane formatter: aligns/extends load data and replicates store
// data with byte enables. Sub-word handling exists only when MEMIO_SUBWORD_EN
// is defined; otherwise every access is a full word with all byte lanes enabled.
module lane_formatter
    import memio_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  byte_off,
    input  logic [31:0] load_word,
    input  logic [31:0] store_word,
    output logic [31:0] load_val,
    output logic [31:0] store_val,
    output logic [3:0]  byte_en,
    output logic        misaligned
);

`ifdef MEMIO_SUBWORD_EN
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed lane and build the extended load / replicated store
    always_comb begin
        byte_lane  = 8'(load_word >> {byte_off, 3'b000});
        half_lane  = 16'(load_word >> {byte_off[1], 4'b0000});
        load_val   = load_word;
        store_val  = store_word;
        byte_en    = 4'hF;
        misaligned = 1'b0;
        case (opcode)
            OP_LB:  load_val = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU: load_val = {24'h000000, byte_lane};
            OP_LH: begin
                misaligned = byte_off[0];
                load_val   = {{16{half_lane[15]}}, half_lane};
            end
            OP_LHU: begin
                misaligned = byte_off[0];
                load_val   = {16'h0000, half_lane};
            end
            OP_SB: begin
                store_val = {4{store_word[7:0]}};
                byte_en   = 4'b0001 << byte_off;
            end
            OP_SH: begin
                misaligned = byte_off[0];
                store_val  = {2{store_word[15:0]}};
                byte_en    = byte_off[0] ? 4'b0000 : (4'b0011 << byte_off);
            end
            default: ;
        endcase
    end
`else
    logic unused_fmt;

    assign load_val   = load_word;
    assign store_val  = store_word;
    assign byte_en    = 4'hF;
    assign misaligned = 1'b0;
    assign unused_fmt = ^{opcode, byte_off};
`endif

endmodule

// File: rtl/mem_io_unit.sv
// Data-side access unit: decodes the ALU result as a byte address and routes
// loads/stores to the synchronous data RAM or to the I/O bus, stalling the core
// during multi-cycle accesses. Optional sub-word accesses: MEMIO_SUBWORD_EN.
module mem_io_unit
    import memio_pkg::*;
#(
    parameter int          RAM_AW  = 14,
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
    parameter logic [7:0]  IO_TMO  = 8'd255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [5:0]        opcode,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       mem_data,
    output logic              stall,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_we,
    input  logic [31:0]       ram_rdata,
    output logic              io_req,
    output logic              io_we,
    output logic [9:0]        io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ack
);

    state_t      state_q, state_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        bus_err_q, bus_err_d;
    logic        io_req_q, io_req_d;
    logic        io_we_q, io_we_d;
    logic [7:0]  timer_q, timer_d;

    logic        is_io;
    logic [31:0] load_val;
    logic [31:0] store_val;
    logic [3:0]  byte_en;
    logic        misaligned;

    lane_formatter u_fmt (
        .opcode     (opcode),
        .byte_off   (addr[1:0]),
        .load_word  (ram_rdata),
        .store_word (store_data),
        .load_val   (load_val),
        .store_val  (store_val),
        .byte_en    (byte_en),
        .misaligned (misaligned)
    );

    assign is_io     = (addr[31:10] == IO_BASE[31:10]);
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = store_val;
    assign io_addr   = addr[9:0];
    assign io_wdata  = store_val;
    assign mem_data  = mem_data_q;
    assign bus_err   = bus_err_q;
    assign io_req    = io_req_q;
    assign io_we     = io_we_q;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a read with a simultaneous write is handled as a read
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mem_read)
                    state_d = is_io ? S_IO_WAIT : S_RAM_RD;
                else if (mem_write && is_io && !misaligned)
                    state_d = S_IO_WAIT;
            end
            S_RAM_RD:  state_d = S_DONE;
            S_IO_WAIT: if (io_ack || (timer_q == IO_TMO)) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs and next values of the datapath registers
    always_comb begin
        stall      = 1'b0;
        ram_we     = '0;
        mem_data_d = mem_data_q;
        bus_err_d  = bus_err_q;
        io_req_d   = io_req_q;
        io_we_d    = io_we_q;
        timer_d    = timer_q;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (mem_read) begin
                    stall = 1'b1;
                    if (mem_write || misaligned) bus_err_d = 1'b1;
                    if (is_io) begin
                        io_req_d = 1'b1;
                        io_we_d  = 1'b0;
                    end
                end else if (mem_write) begin
                    if (misaligned) begin
                        bus_err_d = 1'b1;
                    end else if (is_io) begin
                        stall    = 1'b1;
                        io_req_d = 1'b1;
                        io_we_d  = 1'b1;
                    end else begin
                        ram_we = byte_en;
                    end
                end
            end
            S_RAM_RD: begin
                stall      = 1'b1;
                mem_data_d = load_val;
            end
            S_IO_WAIT: begin
                stall   = 1'b1;
                timer_d = timer_q + 8'd1;
                if (io_ack) begin
                    if (!io_we_q) mem_data_d = io_rdata;
                    io_req_d = 1'b0;
                end else if (timer_q == IO_TMO) begin
                    if (!io_we_q) mem_data_d = IO_TIMEOUT_DATA;
                    bus_err_d = 1'b1;
                    io_req_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_data_q <= '0;
            bus_err_q  <= 1'b0;
            io_req_q   <= 1'b0;
            io_we_q    <= 1'b0;
            timer_q    <= '0;
        end else begin
            mem_data_q <= mem_data_d;
            bus_err_q  <= bus_err_d;
            io_req_q   <= io_req_d;
            io_we_q    <= io_we_d;
            timer_q    <= timer_d;
        end
    end

endmodule

// File: tb/tb_mem_io_unit.sv
// Self-checking bench for mem_io_unit: table-driven RAM vectors, random RAM
// traffic against a shadow-memory model, and hand-written I/O, timeout, reset
// and conflict sequences. Sub-word checks appear when MEMIO_SUBWORD_EN is defined.
module tb_mem_io_unit;
    import memio_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [5:0]  opcode = OP_LW;
    logic [31:0] addr = '0, store_data = '0;
    logic [31:0] mem_data;
    logic        stall, bus_err;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata = '0;
    logic        io_req, io_we;
    logic [9:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata = '0;
    logic        io_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    mem_io_unit #(.RAM_AW(14), .IO_BASE(32'hFFFFFC00), .IO_TMO(8'd255)) dut (
        .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .opcode(opcode), .addr(addr), .store_data(store_data), .mem_data(mem_data),
        .stall(stall), .bus_err(bus_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata), .io_req(io_req), .io_we(io_we),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
    );

    always #5 clock = ~clock;

    // Synchronous data RAM: byte-lane writes, registered read of the old data
    logic [31:0] ram [0:16383];
    always @(posedge clock) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= ram[ram_addr];
    end

    // I/O slave: acknowledges in the ack_delay-th cycle io_req is seen high (0 = never)
    int          ack_delay = 0;
    int          io_cnt = 0;
    int          io_hi = 0;
    logic [9:0]  wr_addr_log = '0;
    logic [31:0] wr_data_log = '0;
    initial begin
        forever begin
            @(posedge clock); #1;
            if (io_req) begin
                io_cnt++;
                io_hi++;
            end else begin
                io_cnt = 0;
            end
            io_ack = io_req && (ack_delay > 0) && (io_cnt == ack_delay);
            if (io_ack && io_we) begin
                wr_addr_log = io_addr;
                wr_data_log = io_wdata;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One core-side access: request held while stall is high, released after the
    // first stall-free cycle, where the result is sampled.
    task automatic access(input bit rd, input bit wr, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] got, output int stalls,
                          output logic [3:0] we_seen);
        mem_read = rd; mem_write = wr; opcode = op; addr = a; store_data = d;
        stalls = 0; we_seen = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            we_seen = we_seen | ram_we;
            if (!stall) break;
            stalls++;
            @(posedge clock); #1;
        end
        got = mem_data;
        @(posedge clock); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_data;
        int          exp_stall;
        logic [3:0]  exp_we;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] got;
    int          st;
    logic [3:0]  we;
    logic [31:0] shadow [int];
    int          wq [$];
    logic [31:0] last_load;

    initial begin
        vecs[0] = '{1'b1, 32'h00000010, 32'h12345678, 32'h00000000, 0, 4'hF};
        vecs[1] = '{1'b0, 32'h00000010, 32'h0,        32'h12345678, 2, 4'h0};
        vecs[2] = '{1'b1, 32'h00000014, 32'hDEADC0DE, 32'h12345678, 0, 4'hF};
        vecs[3] = '{1'b1, 32'h0000FFFC, 32'hA5A5A5A5, 32'h12345678, 0, 4'hF};
        vecs[4] = '{1'b0, 32'h00000014, 32'h0,        32'hDEADC0DE, 2, 4'h0};
        vecs[5] = '{1'b0, 32'h0000FFFC, 32'h0,        32'hA5A5A5A5, 2, 4'h0};
        vecs[6] = '{1'b0, 32'h00010010, 32'h0,        32'h12345678, 2, 4'h0};
        vecs[7] = '{1'b1, 32'h00000020, 32'hCAFEF00D, 32'h12345678, 0, 4'hF};
        vecs[8] = '{1'b0, 32'h00000020, 32'h0,        32'hCAFEF00D, 2, 4'h0};
        vecs[9] = '{1'b0, 32'h00000017, 32'h0,        32'hDEADC0DE, 2, 4'h0};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_mem_data", mem_data, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        check("rst_io_req", {31'b0, io_req}, 32'h0);
        check("rst_ram_we", {28'b0, ram_we}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Table-driven RAM vectors
        foreach (vecs[i]) begin
            access(!vecs[i].wr, vecs[i].wr, vecs[i].wr ? OP_SW : OP_LW,
                   vecs[i].a, vecs[i].d, got, st, we);
            check($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
            check($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d_we", i), {28'b0, we}, {28'b0, vecs[i].exp_we});
        end
        last_load = 32'hDEADC0DE;

        // Random RAM traffic against a shadow memory
        for (int n = 0; n < 200; n++) begin
            int          w;
            logic [31:0] d;
            if (wq.size() == 0 || ($urandom % 2) == 0) begin
                w = $urandom_range(256, 16382);
                d = $urandom;
                access(1'b0, 1'b1, OP_SW, {16'h0, w[13:0], 2'($urandom)}, d, got, st, we);
                if (!shadow.exists(w)) wq.push_back(w);
                shadow[w] = d;
                check("rnd_st_hold", got, last_load);
                check("rnd_st_stall", 32'(st), 32'd0);
                check("rnd_st_we", {28'b0, we}, 32'hF);
            end else begin
                w = wq[$urandom_range(0, wq.size() - 1)];
                access(1'b1, 1'b0, OP_LW, {16'h0, w[13:0], 2'($urandom)}, 32'h0, got, st, we);
                last_load = shadow[w];
                check("rnd_ld_data", got, shadow[w]);
                check("rnd_ld_stall", 32'(st), 32'd2);
            end
        end
        check("bus_err_clean", {31'b0, bus_err}, 32'h0);

        // I/O read, ack in the third waiting cycle
        ack_delay = 3; io_rdata = 32'h000000AB; io_hi = 0;
        access(1'b1, 1'b0, OP_LW, 32'hFFFFFC70, 32'h0, got, st, we);
        check("io_rd_data", got, 32'h000000AB);
        check("io_rd_stall", 32'(st), 32'd4);
        check("io_rd_req_cycles", 32'(io_hi), 32'd3);
        check("io_rd_req_drop", {31'b0, io_req}, 32'h0);

        // I/O write, ack in the first waiting cycle
        ack_delay = 1; io_hi = 0;
        access(1'b0, 1'b1, OP_SW, 32'hFFFFFC04, 32'h000055AA, got, st, we);
        check("io_wr_stall", 32'(st), 32'd2);
        check("io_wr_hold", got, 32'h000000AB);
        check("io_wr_addr", {22'b0, wr_addr_log}, 32'h004);
        check("io_wr_data", wr_data_log, 32'h000055AA);
        check("io_wr_no_ram", {28'b0, we}, 32'h0);
        check("io_no_err", {31'b0, bus_err}, 32'h0);

        // I/O read that is never acknowledged
        ack_delay = 0; io_rdata = 32'h00001234;
        access(1'b1, 1'b0, OP_LW, 32'hFFFFFC70, 32'h0, got, st, we);
        check("tmo_data", got, 32'hDEADBEEF);
        check("tmo_stall_range", {31'b0, (st >= 256 && st <= 258)}, 32'h1);
        check("tmo_bus_err", {31'b0, bus_err}, 32'h1);
        check("tmo_io_req", {31'b0, io_req}, 32'h0);

        // Reset pulled while waiting on the I/O bus
        mem_read = 1'b1; opcode = OP_LW; addr = 32'hFFFFFC70;
        repeat (5) begin @(posedge clock); #1; end
        @(negedge clock);
        check("pre_rst_io_req", {31'b0, io_req}, 32'h1);
        @(posedge clock); #1;
        reset = 1'b0; mem_read = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("midrst_io_req", {31'b0, io_req}, 32'h0);
        check("midrst_stall", {31'b0, stall}, 32'h0);
        check("midrst_mem_data", mem_data, 32'h0);
        check("midrst_bus_err", {31'b0, bus_err}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Simultaneous read and write to RAM: load wins, store suppressed
        access(1'b1, 1'b1, OP_LW, 32'h00000020, 32'h11111111, got, st, we);
        check("both_data", got, 32'hCAFEF00D);
        check("both_stall", 32'(st), 32'd2);
        check("both_no_we", {28'b0, we}, 32'h0);
        check("both_bus_err", {31'b0, bus_err}, 32'h1);
        access(1'b1, 1'b0, OP_LW, 32'h00000020, 32'h0, got, st, we);
        check("both_ram_kept", got, 32'hCAFEF00D);

`ifdef MEMIO_SUBWORD_EN
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        access(1'b0, 1'b1, OP_SW, 32'h0, 32'h80FF7F01, got, st, we);
        access(1'b1, 1'b0, OP_LB, 32'h3, 32'h0, got, st, we);
        check("sub_lb", got, 32'hFFFFFF80);
        access(1'b1, 1'b0, OP_LBU, 32'h2, 32'h0, got, st, we);
        check("sub_lbu", got, 32'h000000FF);
        access(1'b1, 1'b0, OP_LH, 32'h2, 32'h0, got, st, we);
        check("sub_lh", got, 32'hFFFF80FF);
        access(1'b1, 1'b0, OP_LHU, 32'h0, 32'h0, got, st, we);
        check("sub_lhu", got, 32'h00007F01);
        access(1'b0, 1'b1, OP_SB, 32'h1, 32'h000000AA, got, st, we);
        check("sub_sb_we", {28'b0, we}, 32'h2);
        check("sub_no_err", {31'b0, bus_err}, 32'h0);
        access(1'b0, 1'b1, OP_SH, 32'h1, 32'h00001234, got, st, we);
        check("sub_sh_mis_we", {28'b0, we}, 32'h0);
        check("sub_sh_mis_err", {31'b0, bus_err}, 32'h1);
        access(1'b1, 1'b0, OP_LW, 32'h0, 32'h0, got, st, we);
        check("sub_word_after", got, 32'h80FFAA01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
